// File: rtl/ps2_mouse_pkt.sv
// PS/2 mouse receiver: filters the device clock, deframes 11-bit frames and
// assembles 3-byte stream packets into a toggling-strobe 25-bit MOUSE word.
module ps2_mouse_pkt #(
    parameter int FILT   = 8,
    parameter int BIT_TO = 10740,
    parameter int PKT_TO = 107400
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [24:0] MOUSE,
    output logic [7:0]  ERR_CNT
);

    localparam int FW = $clog2(FILT + 1);
    localparam int TW = $clog2(BIT_TO + 1);
    localparam int PW = $clog2(PKT_TO + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_s;
    logic          data_s;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          strobe;

    state_t        state;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] bit_tmr;
    logic [PW-1:0] pkt_tmr;
    logic [1:0]    byte_idx;
    logic [7:0]    status_q;
    logic [7:0]    dx_q;

    logic          byte_done;
    logic          frame_ok;
    logic          sync_bad;
    logic          timeout;
    logic          err_ev;
    logic          good_byte;
    logic [7:0]    dx_sat;
    logic [7:0]    dy_sat;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // Filtered clock only moves after FILT consecutive samples disagree with it;
    // strobe is a one-cycle pulse on each accepted falling transition.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt_clk  <= 1'b1;
            filt_cnt  <= '0;
            strobe    <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], PS2_CLK};
            data_sync <= {data_sync[0], PS2_DATA};
            strobe    <= 1'b0;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
                strobe   <= ~clk_s;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        byte_done = strobe && (state == STOP);
        frame_ok  = data_s && (^{shift, par_bit});
        sync_bad  = (byte_idx == 2'd0) && !shift[3];
        timeout   = (state != IDLE) && !strobe && (bit_tmr == TW'(BIT_TO - 1));
        err_ev    = timeout || (byte_done && (!frame_ok || sync_bad));
        good_byte = byte_done && frame_ok && !sync_bad;
        // Overflowed axes clamp to the 8-bit extreme matching their sign.
        dx_sat    = status_q[6] ? (status_q[4] ? 8'h00 : 8'hFF) : dx_q;
        dy_sat    = status_q[7] ? (status_q[5] ? 8'h00 : 8'hFF) : shift;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            bit_idx  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            bit_tmr  <= '0;
            pkt_tmr  <= '0;
            byte_idx <= '0;
            status_q <= '0;
            dx_q     <= '0;
            MOUSE    <= '0;
            ERR_CNT  <= '0;
        end else begin
            if (strobe || state == IDLE) bit_tmr <= '0;
            else                         bit_tmr <= bit_tmr + 1'b1;

            if (err_ev && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 1'b1;

            if (strobe) begin
                case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_s;
                        state   <= STOP;
                    end
                    default: state <= IDLE;
                endcase
            end else if (timeout) begin
                state <= IDLE;
            end

            // Any error discards the partial packet; a stale packet times out silently.
            if (err_ev) begin
                byte_idx <= '0;
                pkt_tmr  <= '0;
            end else if (good_byte) begin
                pkt_tmr <= '0;
                case (byte_idx)
                    2'd0: begin
                        status_q <= shift;
                        byte_idx <= 2'd1;
                    end
                    2'd1: begin
                        dx_q     <= shift;
                        byte_idx <= 2'd2;
                    end
                    default: begin
                        MOUSE    <= {~MOUSE[24], dy_sat, dx_sat, status_q};
                        byte_idx <= 2'd0;
                    end
                endcase
            end else if (byte_idx != 2'd0) begin
                if (pkt_tmr == PW'(PKT_TO - 1)) begin
                    byte_idx <= '0;
                    pkt_tmr  <= '0;
                end else begin
                    pkt_tmr <= pkt_tmr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_pkt.sv
// Directed bench for ps2_mouse_pkt: drives PS/2 frames bit by bit and checks
// the published MOUSE word and error counter against hand-computed values.
module tb_ps2_mouse_pkt;

    localparam int FILT   = 8;
    localparam int BIT_TO = 300;
    localparam int PKT_TO = 3000;

    logic        clk;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic [24:0] mouse;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    ps2_mouse_pkt #(.FILT(FILT), .BIT_TO(BIT_TO), .PKT_TO(PKT_TO)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .PS2_CLK  (ps2_clk),
        .PS2_DATA (ps2_data),
        .MOUSE    (mouse),
        .ERR_CNT  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        clks(10);
        ps2_clk = 1'b0;
        clks(20);
        ps2_clk = 1'b1;
        clks(10);
    endtask

    // Full 11-bit frame; odd parity unless bad_par flips it.
    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        clks(50);
    endtask

    task automatic send_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
        send_byte(s, 1'b0);
        send_byte(x, 1'b0);
        send_byte(y, 1'b0);
    endtask

    // Start bit plus n data bits, then the device goes silent.
    task automatic send_partial(input logic [7:0] b, input int n);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(b[i]);
        ps2_data = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(5);
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        clks(5);
        @(negedge clk);
        check("reset_mouse", 32'(mouse), 32'h0);
        check("reset_err", 32'(err_cnt), 32'h0);
        rst = 1'b0;
        clks(5);

        // Plain packet
        send_pkt(8'h08, 8'h05, 8'hFB);
        @(negedge clk);
        check("t1_mouse", 32'(mouse), {7'h0, 1'b1, 8'hFB, 8'h05, 8'h08});
        check("t1_err", 32'(err_cnt), 32'h0);

        // X overflow with negative sign clamps dx to 00
        do_reset();
        send_pkt(8'h58, 8'h20, 8'h10);
        @(negedge clk);
        check("t2_mouse", 32'(mouse), {7'h0, 1'b1, 8'h10, 8'h00, 8'h58});
        // Y overflow, positive: dy clamps to FF, stb toggles back
        send_pkt(8'h88, 8'h03, 8'h44);
        @(negedge clk);
        check("t2b_mouse", 32'(mouse), {7'h0, 1'b0, 8'hFF, 8'h03, 8'h88});
        check("t2_err", 32'(err_cnt), 32'h0);

        // Bad parity on byte 2 suppresses the packet
        do_reset();
        send_byte(8'h08, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'hFB, 1'b1);
        @(negedge clk);
        check("t3_no_pub", 32'(mouse), 32'h0);
        check("t3_err", 32'(err_cnt), 32'h1);
        send_pkt(8'h09, 8'h07, 8'h06);
        @(negedge clk);
        check("t3_mouse", 32'(mouse), {7'h0, 1'b1, 8'h06, 8'h07, 8'h09});
        check("t3_err2", 32'(err_cnt), 32'h1);

        // Missing sync bit drops the first byte
        do_reset();
        send_byte(8'h05, 1'b0);
        @(negedge clk);
        check("t4_err", 32'(err_cnt), 32'h1);
        send_pkt(8'h09, 8'h01, 8'h02);
        @(negedge clk);
        check("t4_mouse", 32'(mouse), {7'h0, 1'b1, 8'h02, 8'h01, 8'h09});
        check("t4_err2", 32'(err_cnt), 32'h1);

        // Bit timeout mid-frame
        do_reset();
        send_partial(8'h08, 4);
        clks(BIT_TO / 2);
        @(negedge clk);
        check("t5_before_to", 32'(err_cnt), 32'h0);
        clks(BIT_TO);
        @(negedge clk);
        check("t5_err", 32'(err_cnt), 32'h1);
        check("t5_no_pub", 32'(mouse), 32'h0);
        send_pkt(8'h08, 8'h05, 8'hFB);
        @(negedge clk);
        check("t5_mouse", 32'(mouse), {7'h0, 1'b1, 8'hFB, 8'h05, 8'h08});
        check("t5_err2", 32'(err_cnt), 32'h1);

        // Reset mid-frame clears everything
        send_partial(8'h08, 3);
        rst = 1'b1;
        clks(2);
        @(negedge clk);
        check("rst_mid_mouse", 32'(mouse), 32'h0);
        check("rst_mid_err", 32'(err_cnt), 32'h0);
        rst = 1'b0;
        clks(BIT_TO);
        send_pkt(8'h0A, 8'h11, 8'h22);
        @(negedge clk);
        check("rst_mid_pkt", 32'(mouse), {7'h0, 1'b1, 8'h22, 8'h11, 8'h0A});
        check("rst_mid_err2", 32'(err_cnt), 32'h0);

        // Packet timeout discards a partial packet silently
        do_reset();
        send_byte(8'h08, 1'b0);
        send_byte(8'h05, 1'b0);
        clks(PKT_TO + 1000);
        @(negedge clk);
        check("t6_partial", 32'(mouse), 32'h0);
        send_pkt(8'h08, 8'h01, 8'h01);
        @(negedge clk);
        check("t6_mouse", 32'(mouse), {7'h0, 1'b1, 8'h01, 8'h01, 8'h08});
        check("t6_err", 32'(err_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
